// File: rtl/opb_status_bank_pkg.sv
// Shared constants and state encodings for opb_status_bank.
// Word map, CTRL field positions, ack and capture FSM states.
package opb_status_bank_pkg;

  localparam int WORD_W    = 6;
  localparam int W_CTRL    = 0;
  localparam int W_CH0     = 1;
  localparam int W_STICKY0 = 16;

  localparam int CTRL_HOLD   = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_CNT_LO = 8;
  localparam int CTRL_NCH_LO = 16;

  typedef enum logic [1:0] {
    A_IDLE,
    A_ACK,
    A_GAP
  } ack_st_t;

  typedef enum logic {
    C_LIVE,
    C_HOLD
  } cap_st_t;

  function automatic logic [31:0] ctrl_word(
    input logic       hold,
    input logic [7:0] cnt,
    input logic [7:0] nch
  );
    logic [31:0] w;
    w = '0;
    w[CTRL_HOLD] = hold;
    w[CTRL_CNT_LO +: 8] = cnt;
    w[CTRL_NCH_LO +: 8] = nch;
    return w;
  endfunction

endpackage

// File: rtl/opb_status_bank_slv.sv
// OPB slave front end: window decode, request latch and ack FSM.
// Read data is gated to zero outside read acknowledges.
module opb_status_bank_slv
  import opb_status_bank_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0108_0200,
  parameter logic [31:0] HIGH = 32'h0108_02FF,
  parameter int          AW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     abus,
  input  logic              select,
  input  logic              rnw,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic              ack,
  output logic              wr_en,
  output logic [WORD_W-1:0] idx,
  output logic [31:0]       wdat_q,
  output logic [3:0]        be_q,
  output logic [31:0]       dbus
);

  ack_st_t     st, st_nx;
  logic        hit;
  logic        rnw_q;
  logic [AW-1:0] off;
  logic        unused_off;

  assign off = abus - BASE[AW-1:0];
  assign hit = select
             && (abus >= BASE[AW-1:0])
             && (abus <= HIGH[AW-1:0]);
  assign unused_off = ^{off[AW-1:8], off[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= A_IDLE;
    end else begin
      st <= st_nx;
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      A_IDLE: if (hit) st_nx = A_ACK;
      A_ACK:  st_nx = A_GAP;
      A_GAP:  st_nx = A_IDLE;
      default: st_nx = A_IDLE;
    endcase
  end

  // Request is captured on the hit so the ACK cycle never depends
  // on the master still holding the bus steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      rnw_q  <= 1'b0;
      wdat_q <= '0;
      be_q   <= '0;
    end else if (st == A_IDLE && hit) begin
      idx    <= off[7:2];
      rnw_q  <= rnw;
      wdat_q <= wdata;
      be_q   <= be;
    end
  end

  assign ack   = (st == A_ACK);
  assign wr_en = ack && !rnw_q;
  assign dbus  = (ack && rnw_q) ? rdata : '0;

endmodule

// File: rtl/opb_status_bank.sv
// OPB status bank: CTRL word, snapshot channels, optional sticky bits.
// Sticky regs at words 16+k exist only with OPB_STATUS_BANK_STICKY_EN.
module opb_status_bank
  import opb_status_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0108_0200,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108_02FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_CH     = 4,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                  OPB_Clk,
  input  logic                  OPB_Rst,
  input  logic [0:31]           OPB_ABus,
  input  logic [0:3]            OPB_BE,
  input  logic [0:31]           OPB_DBus,
  input  logic                  OPB_RNW,
  input  logic                  OPB_select,
  input  logic                  OPB_seqAddr,
  output logic [0:31]           Sl_DBus,
  output logic                  Sl_errAck,
  output logic                  Sl_retry,
  output logic                  Sl_toutSup,
  output logic                  Sl_xferAck,
  input  logic [32*C_NUM_CH-1:0] user_data_in
);

  localparam bit unused_fam = (C_FAMILY != "");
  localparam bit unused_dw  = (C_OPB_DWIDTH == 32);

  logic              wr_en;
  logic [WORD_W-1:0] idx;
  logic [31:0]       wdat;
  logic [3:0]        be_q;
  logic [31:0]       rdata;
  logic [31:0]       dbus;
  logic              ack;

  opb_status_bank_slv #(
    .BASE (C_BASEADDR),
    .HIGH (C_HIGHADDR),
    .AW   (C_OPB_AWIDTH)
  ) u_slv (
    .clk    (OPB_Clk),
    .rst    (OPB_Rst),
    .abus   (OPB_ABus),
    .select (OPB_select),
    .rnw    (OPB_RNW),
    .be     (OPB_BE),
    .wdata  (OPB_DBus),
    .rdata  (rdata),
    .ack    (ack),
    .wr_en  (wr_en),
    .idx    (idx),
    .wdat_q (wdat),
    .be_q   (be_q),
    .dbus   (dbus)
  );

  assign Sl_DBus    = dbus;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  int   widx;
  int   ch_sel;
  logic is_ctrl;
  logic is_ch;

  assign widx    = int'(idx);
  assign ch_sel  = widx - W_CH0;
  assign is_ctrl = (widx == W_CTRL);
  assign is_ch   = (widx >= W_CH0) && (widx < W_CH0 + C_NUM_CH);

  // be_q[0] is OPB_BE[3], the lane carrying CTRL bits 7:0.
  cap_st_t cap_st, cap_nx;
  logic    ctrl_wr;
  logic    capture;
  logic    clear;
  logic    load;
  logic [7:0] cnt;
  logic [32*C_NUM_CH-1:0] snap;

  assign ctrl_wr = wr_en && is_ctrl && be_q[0];
  assign capture = ctrl_wr && wdat[CTRL_HOLD];
  assign clear   = ctrl_wr && wdat[CTRL_CLR];

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      cap_st <= C_LIVE;
    end else begin
      cap_st <= cap_nx;
    end
  end

  always_comb begin
    cap_nx = cap_st;
    load   = (cap_st == C_LIVE);
    if (ctrl_wr) begin
      cap_nx = wdat[CTRL_HOLD] ? C_HOLD : C_LIVE;
    end
    if (capture) begin
      load = 1'b1;
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      snap <= '0;
    end else if (load) begin
      snap <= user_data_in;
    end
  end

  // Clear wins over increment; a combined clear+capture lands on 1.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= {7'd0, capture};
    end else if (capture) begin
      cnt <= cnt + 8'd1;
    end
  end

`ifdef OPB_STATUS_BANK_STICKY_EN
  int   stk_sel;
  logic is_stk;
  logic [31:0] be_mask;
  logic [32*C_NUM_CH-1:0] sticky;
  logic [32*C_NUM_CH-1:0] stk_clr;

  assign stk_sel = widx - W_STICKY0;
  assign is_stk  = (widx >= W_STICKY0)
                && (widx < W_STICKY0 + C_NUM_CH);
  assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}},
                    {8{be_q[1]}}, {8{be_q[0]}}};

  always_comb begin
    stk_clr = '0;
    if (wr_en && is_stk) begin
      stk_clr[32*stk_sel +: 32] = wdat & be_mask;
    end
  end

  // Set is ORed in after the clear so a live bit survives W1C.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~stk_clr) | user_data_in;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_ctrl: rdata = ctrl_word(cap_st == C_HOLD, cnt,
                                 8'(C_NUM_CH));
      is_ch:   rdata = snap[32*ch_sel +: 32];
`ifdef OPB_STATUS_BANK_STICKY_EN
      is_stk:  rdata = sticky[32*stk_sel +: 32];
`endif
      default: rdata = '0;
    endcase
  end

  logic unused_in;
  assign unused_in = ^{OPB_seqAddr, wdat, be_q,
                       unused_fam, unused_dw};

endmodule

// File: tb/tb_opb_status_bank.sv
// Scoreboard bench for opb_status_bank: directed OPB transfers,
// expected read data queued at issue and checked on each ack.
module tb_opb_status_bank;

  localparam logic [31:0] BASE = 32'h0108_0200;
  localparam logic [31:0] HIGH = 32'h0108_02FF;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] wdata;
  logic rnw, sel, seq;
  logic [0:31] sl_dbus;
  logic err, retry, tout, ack;
  logic [32*NCH-1:0] udi;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  opb_status_bank #(.C_NUM_CH(NCH)) dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (wdata),
    .OPB_RNW      (rnw),
    .OPB_select   (sel),
    .OPB_seqAddr  (seq),
    .Sl_DBus      (sl_dbus),
    .Sl_errAck    (err),
    .Sl_retry     (retry),
    .Sl_toutSup   (tout),
    .Sl_xferAck   (ack),
    .user_data_in (udi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every ack consumes one queued expectation.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_ack: got ack=1 want none");
      end else begin
        check("ack_data", sl_dbus, exp_q.pop_front());
        check("tied_outs", {29'd0, err, retry, tout}, 32'd0);
      end
    end
  end

  task automatic op(input logic [31:0] a, input logic w,
                    input logic [31:0] d, input logic [3:0] b,
                    input logic [31:0] exp_rd);
    @(negedge clk);
    abus = a; rnw = ~w; wdata = d; be = b; sel = 1'b1;
    exp_q.push_back(w ? 32'd0 : exp_rd);
    @(posedge clk);
    #1 check("ack_latency", {31'd0, ack}, 32'd1);
    @(posedge clk);
    #1 sel = 1'b0; abus = '0; wdata = '0;
    @(posedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    op(a, 1'b0, 32'd0, 4'hF, e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    op(a, 1'b1, d, 4'hF, 32'd0);
  endtask

  task automatic no_ack(input string name, input logic [31:0] a);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    abus = a; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1 if (ack) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd0);
    sel = 1'b0; abus = '0;
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; rnw = 1'b1; seq = 1'b0;
    abus = '0; wdata = '0; be = 4'h0; udi = '0;
    repeat (2) @(posedge clk);
    #1 check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dbus", sl_dbus, 32'd0);
    @(negedge clk) rst = 1'b0;

    udi[31:0] = 32'hDEAD_BEEF;
    rd(BASE + 32'h4, 32'hDEAD_BEEF);

    wr(BASE, 32'h1);
    udi[31:0] = 32'h1234_5678;
    rd(BASE + 32'h4, 32'hDEAD_BEEF);
    rd(BASE, 32'h0004_0101);

    for (int i = 0; i < 255; i++) wr(BASE, 32'h1);
    rd(BASE, 32'h0004_0001);
    wr(BASE, 32'h3);
    rd(BASE, 32'h0004_0101);

    op(BASE, 1'b1, 32'h0, 4'b1110, 32'd0);
    rd(BASE, 32'h0004_0101);

    wr(BASE, 32'h2);
    rd(BASE, 32'h0004_0000);
    rd(BASE + 32'h4, 32'h1234_5678);
    udi[127:96] = 32'hCAFE_F00D;
    rd(BASE + 32'h10, 32'hCAFE_F00D);
    rd(BASE + 32'h14, 32'h0);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    rd(BASE, 32'h0004_0000);

    rd(BASE + 32'h3C, 32'h0);
    no_ack("above_high", HIGH + 32'h4);
    no_ack("below_base", BASE - 32'h4);

`ifdef OPB_STATUS_BANK_STICKY_EN
    @(negedge clk) udi[69] = 1'b1;
    @(negedge clk) udi[69] = 1'b0;
    rd(BASE + 32'h48, 32'h20);
    udi[69] = 1'b1;
    wr(BASE + 32'h48, 32'h20);
    rd(BASE + 32'h48, 32'h20);
    udi[69] = 1'b0;
    wr(BASE + 32'h48, 32'h20);
    rd(BASE + 32'h48, 32'h0);
`else
    @(negedge clk) udi[69] = 1'b1;
    @(negedge clk) udi[69] = 1'b0;
    rd(BASE + 32'h48, 32'h0);
    rd(BASE + 32'h40, 32'h0);
`endif

    wr(BASE, 32'h1);
    rd(BASE, 32'h0004_0101);
    @(negedge clk);
    abus = BASE; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    @(posedge clk);
    #1 check("ack_pre_rst", {31'd0, ack}, 32'd1);
    rst = 1'b1;
    #1 check("rst_in_ack", {31'd0, ack}, 32'd0);
    check("rst_in_ack_dbus", sl_dbus, 32'd0);
    sel = 1'b0; abus = '0;
    @(negedge clk) rst = 1'b0;
    rd(BASE, 32'h0004_0000);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/opb_status_bank.md
OPB_STATUS_BANK -- requirements
Module: opb_status_bank

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01080200: base address of the block's OPB window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h010802FF: high address of the window (256 B).
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32: OPB address width.
REQ-004 SHALL have parameter C_OPB_DWIDTH, default 32: OPB data width; only 32 is supported.
REQ-005 SHALL have parameter C_NUM_CH, default 4: number of 32-bit status channels, legal range 1..15.
REQ-006 SHALL have parameter C_FAMILY, default "virtex5": target family, informational only.
REQ-007 SHALL have port OPB_Clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-008 SHALL have port OPB_Rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port OPB_ABus, input, [0:31]: OPB address.
REQ-010 SHALL have port OPB_BE, input, [0:3]: byte enables.
REQ-011 SHALL have port OPB_DBus, input, [0:31]: write data.
REQ-012 SHALL have port OPB_RNW, input, 1 bit: 1 = read, 0 = write.
REQ-013 SHALL have port OPB_select, input, 1 bit: transfer request.
REQ-014 SHALL have port OPB_seqAddr, input, 1 bit: sequential hint, ignored.
REQ-015 SHALL have port Sl_DBus, output, [0:31]: read data.
REQ-016 SHALL have ports Sl_errAck, Sl_retry and Sl_toutSup, outputs, 1 bit each, tied to 0.
REQ-017 SHALL have port Sl_xferAck, output, 1 bit: transfer acknowledge.
REQ-018 SHALL have port user_data_in, input, [32*C_NUM_CH-1:0]: channel k occupies bits [32k+31:32k].

Function
REQ-019 SHALL decode a hit when OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word index = (OPB_ABus-C_BASEADDR)>>2.
REQ-020 SHALL implement an ack FSM: IDLE --hit--> ACK (Sl_xferAck=1 for exactly one cycle) --> GAP (one cycle, no ack) --> IDLE; latency from select to ack is 1 cycle.
REQ-021 SHALL drive Sl_DBus to 0 whenever Sl_xferAck=0.
REQ-022 SHALL map word 0 = CTRL, words 1..C_NUM_CH = channel k-1 snapshot; all other words read 0, ignore writes, and are still acked.
REQ-023 SHALL implement CTRL read fields (LSB numbering): bit0 = HOLD, bits15:8 = snapshot count, bits23:16 = C_NUM_CH; all other bits read 0.
REQ-024 SHALL implement a capture FSM: LIVE (snapshot regs load user_data_in every cycle) and HOLD (snapshot regs frozen).
REQ-025 SHALL accept a CTRL write only when OPB_BE[3]=1; bit0=1 captures all channels in that cycle, enters or stays in HOLD, and increments the count; bit0=0 enters LIVE.
REQ-026 SHALL clear the snapshot count when CTRL bit1=1 is written; a simultaneous capture SHALL leave the count at 1.
REQ-027 SHALL wrap the snapshot count 255 -> 0.
REQ-028 SHALL perform the register update of a write in the ACK cycle; a read in the ACK cycle returns the pre-write value.

Reset
REQ-029 SHALL, on OPB_Rst=1, immediately set ack FSM=IDLE, capture FSM=LIVE, count=0, snapshot regs=0, Sl_xferAck=0 and Sl_DBus=0; a transfer in flight SHALL be dropped without ack.

Configuration
REQ-030 SHALL, with OPB_STATUS_BANK_STICKY_EN defined, add per-channel sticky regs at words 16+k: each cycle sticky |= user_data_in[k], writes clear bits written as 1 (W1C), and a same-cycle set takes priority over clear; reset value is 0.
REQ-031 SHALL, without OPB_STATUS_BANK_STICKY_EN, read words 16..31 as 0 and contain no sticky logic.

Structure
REQ-032 SHALL place the word-index constants, CTRL bit positions and both FSM state encodings in package opb_status_bank_pkg.
REQ-033 SHALL place the address decode and ack FSM in sub-module opb_status_bank_slv; the capture and sticky datapath stays in the top module.

Verification
REQ-034 SHALL cover: reset, then read word 1 with ch0=0xDEADBEEF (LIVE) -> ack 1 cycle after select, Sl_DBus=0xDEADBEEF.
REQ-035 SHALL cover: write CTRL=0x1, change ch0 to 0x12345678, read word 1 -> 0xDEADBEEF; read CTRL -> 0x00040101 (C_NUM_CH=4).
REQ-036 SHALL cover: 256 captures -> count reads 0; then write CTRL=0x3 -> count=1, HOLD=1.
REQ-037 SHALL cover: read address C_BASEADDR+0x3C -> acked, data 0; address C_HIGHADDR+4 -> no ack.
REQ-038 SHALL cover (STICKY_EN): pulse ch2 bit5 for one cycle, read word 18 -> 0x20; W1C 0x20 with bit5 held high -> reads 0x20.
REQ-039 SHALL cover: assert OPB_Rst in the ACK cycle -> Sl_xferAck=0 in the same cycle, and CTRL reads 0x00040000 afterwards.
